spi_peripheral: RTL and testbench

SPI peripheral-side (slave) controller with an Avalon-MM register interface; the counterpart to our SPI master controller. It receives spi_clk, spi_cs_n and spi_mosi from an external master, and drives spi_miso. Transfers are 1–32 bits, MSB first, with any CPOL/CPHA mode. The CPU loads transmit data and reads received data through four 32-bit registers, and gets an optional receive interrupt.

---
 rtl/spi_peripheral.sv | 186 ++++++++++++++++++
 tb/tb_spi_peripheral.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI peripheral (slave) with an Avalon-MM register window. SPI pins are
// oversampled in the avmm_clk domain; any CPOL/CPHA mode, 1-32 bit words, MSB first.
module spi_peripheral (
    input  logic        avmm_clk,
    input  logic        avmm_reset,
    input  logic        avmm_cs,
    input  logic [1:0]  avmm_addr,
    input  logic        avmm_write,
    input  logic [31:0] avmm_writedata,
    input  logic        avmm_read,
    output logic [31:0] avmm_readdata,
    output logic        irq,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} state_t;

    state_t      state, next_state;

    logic        clk_meta, clk_sync, clk_prev;
    logic        cs_meta, cs_sync, cs_prev;
    logic        mosi_meta, mosi_sync;

    logic [31:0] ctrl_q, tx_data_q, rx_data_q, tx_shift, rx_shift;
    logic        tx_empty, rx_valid, overrun, underrun, abort_flag;
    logic [5:0]  len_q, bit_cnt, cfg_len;
    logic [4:0]  cfg_msb, len_msb;
    logic        cpol_q, cpha_q, first_q, miso_q;

    logic        clk_rise, clk_fall, cs_rise, cs_fall;
    logic        lead_edge, trail_edge, sample_edge, shift_edge;
    logic        reg_write, reg_read, wr_ctrl, wr_status, wr_tx, rd_rx, busy;
    logic        do_load, do_sample, do_shift, do_commit, do_abort;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) begin
            {clk_meta, clk_sync, clk_prev} <= 3'b000;
            {cs_meta, cs_sync, cs_prev}    <= 3'b111;
            {mosi_meta, mosi_sync}         <= 2'b00;
        end else begin
            {clk_meta, clk_sync, clk_prev} <= {spi_clk, clk_meta, clk_sync};
            {cs_meta, cs_sync, cs_prev}    <= {spi_cs_n, cs_meta, cs_sync};
            {mosi_meta, mosi_sync}         <= {spi_mosi, mosi_meta};
        end
    end

    assign clk_rise    = clk_sync & ~clk_prev;
    assign clk_fall    = ~clk_sync & clk_prev;
    assign cs_rise     = cs_sync & ~cs_prev;
    assign cs_fall     = ~cs_sync & cs_prev;
    assign lead_edge   = cpol_q ? clk_fall : clk_rise;
    assign trail_edge  = cpol_q ? clk_rise : clk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign cfg_len = (ctrl_q[10:3] == 8'd0 || ctrl_q[10:3] > 8'd32) ? 6'd32 : ctrl_q[8:3];
    assign cfg_msb = 5'(cfg_len - 6'd1);
    assign len_msb = 5'(len_q - 6'd1);

    assign reg_write = avmm_cs & avmm_write;
    assign reg_read  = avmm_cs & avmm_read & ~avmm_write;
    assign wr_ctrl   = reg_write & (avmm_addr == 2'd0);
    assign wr_status = reg_write & (avmm_addr == 2'd1);
    assign wr_tx     = reg_write & (avmm_addr == 2'd2);
    assign rd_rx     = reg_read  & (avmm_addr == 2'd3);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (ctrl_q[0] && cs_fall) next_state = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) next_state = (bit_cnt == len_q) ? ST_DONE : ST_IDLE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // With cpha=1 the first leading edge only launches the already-presented MSB.
    always_comb begin
        do_load   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        do_commit = 1'b0;
        do_abort  = 1'b0;
        case (state)
            ST_IDLE:   do_load = ctrl_q[0] & cs_fall;
            ST_ACTIVE: begin
                do_sample = sample_edge & (bit_cnt < len_q);
                do_shift  = shift_edge & ~(cpha_q & first_q);
                do_abort  = cs_rise & (bit_cnt != len_q);
            end
            ST_DONE:   do_commit = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            len_q    <= 6'd0;
            tx_shift <= 32'd0;
            rx_shift <= 32'd0;
            bit_cnt  <= 6'd0;
            first_q  <= 1'b0;
            miso_q   <= 1'b0;
        end else if (do_load) begin
            cpol_q   <= ctrl_q[1];
            cpha_q   <= ctrl_q[2];
            len_q    <= cfg_len;
            tx_shift <= tx_data_q;
            rx_shift <= 32'd0;
            bit_cnt  <= 6'd0;
            first_q  <= 1'b1;
            miso_q   <= tx_data_q[cfg_msb];
        end else if (state == ST_ACTIVE) begin
            if (do_sample) begin
                rx_shift <= {rx_shift[30:0], mosi_sync};
                bit_cnt  <= bit_cnt + 6'd1;
            end
            if (do_shift)  tx_shift <= tx_shift << 1;
            if (lead_edge) first_q  <= 1'b0;
            miso_q <= tx_shift[len_msb];
        end else begin
            miso_q <= 1'b0;
        end
    end

    // Register file: event-driven sets take priority over CPU clears.
    always_ff @(posedge avmm_clk) begin
        if (avmm_reset) begin
            ctrl_q        <= 32'h81;
            tx_data_q     <= 32'd0;
            tx_empty      <= 1'b1;
            rx_data_q     <= 32'd0;
            rx_valid      <= 1'b0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            abort_flag    <= 1'b0;
            avmm_readdata <= 32'd0;
        end else begin
            if (wr_ctrl) ctrl_q <= avmm_writedata;
            if (wr_tx)   tx_data_q <= avmm_writedata;

            if (wr_tx)        tx_empty <= 1'b0;
            else if (do_load) tx_empty <= 1'b1;

            if (do_load && tx_empty)                underrun <= 1'b1;
            else if (wr_status && avmm_writedata[4]) underrun <= 1'b0;

            if (do_commit && rx_valid)               overrun <= 1'b1;
            else if (wr_status && avmm_writedata[3]) overrun <= 1'b0;

            if (do_abort)                            abort_flag <= 1'b1;
            else if (wr_status && avmm_writedata[5]) abort_flag <= 1'b0;

            if (do_commit) rx_data_q <= rx_shift;

            if (do_commit)  rx_valid <= 1'b1;
            else if (rd_rx) rx_valid <= 1'b0;

            if (reg_read) begin
                case (avmm_addr)
                    2'd0:    avmm_readdata <= ctrl_q;
                    2'd1:    avmm_readdata <= {26'd0, abort_flag, underrun, overrun,
                                               tx_empty, rx_valid, busy};
                    2'd2:    avmm_readdata <= tx_data_q;
                    default: avmm_readdata <= rx_data_q;
                endcase
            end
        end
    end

    assign irq      = ctrl_q[19] & rx_valid;
    assign spi_miso = miso_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a bus-functional SPI master plus a
// transaction-level register model that predicts every readback and idle output.
module tb_spi_peripheral;

    localparam int HALF = 6;

    logic        avmm_clk = 1'b0;
    logic        avmm_reset = 1'b1;
    logic        avmm_cs = 1'b0;
    logic [1:0]  avmm_addr = 2'd0;
    logic        avmm_write = 1'b0;
    logic [31:0] avmm_writedata = 32'd0;
    logic        avmm_read = 1'b0;
    logic [31:0] avmm_readdata;
    logic        irq;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;

    int vec_count = 0;
    int err_count = 0;

    // Model of the programmer-visible state, updated once per bus access or transfer.
    logic [31:0] m_ctrl = 32'h81;
    logic [31:0] m_tx = 32'd0;
    logic [31:0] m_rx = 32'd0;
    logic        m_tx_empty = 1'b1;
    logic        m_rx_valid = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_udr = 1'b0;
    logic        m_abort = 1'b0;
    logic        settled = 1'b0;

    always #5 avmm_clk = ~avmm_clk;

    spi_peripheral dut (
        .avmm_clk       (avmm_clk),
        .avmm_reset     (avmm_reset),
        .avmm_cs        (avmm_cs),
        .avmm_addr      (avmm_addr),
        .avmm_write     (avmm_write),
        .avmm_writedata (avmm_writedata),
        .avmm_read      (avmm_read),
        .avmm_readdata  (avmm_readdata),
        .irq            (irq),
        .spi_clk        (spi_clk),
        .spi_cs_n       (spi_cs_n),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso)
    );

    function automatic int effLen(input logic [31:0] c);
        int f;
        f = int'(c[10:3]);
        return (f == 0 || f > 32) ? 32 : f;
    endfunction

    function automatic logic [31:0] lenMask(input int len);
        return (len >= 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    endfunction

    function automatic logic [31:0] modelStatus();
        return {26'd0, m_abort, m_udr, m_ovr, m_tx_empty, m_rx_valid, 1'b0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Between transfers irq must follow the model and miso must stay low.
    always @(posedge avmm_clk) begin
        #2;
        if (settled) begin
            checkOutput("irq_idle", {31'd0, irq}, {31'd0, m_ctrl[19] & m_rx_valid});
            checkOutput("miso_idle", {31'd0, spi_miso}, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        @(negedge avmm_clk);
        avmm_cs = 1'b1; avmm_write = 1'b1; avmm_addr = addr; avmm_writedata = data;
        case (addr)
            2'd0: m_ctrl = data;
            2'd1: begin
                if (data[3]) m_ovr = 1'b0;
                if (data[4]) m_udr = 1'b0;
                if (data[5]) m_abort = 1'b0;
            end
            2'd2: begin m_tx = data; m_tx_empty = 1'b0; end
            default: ;
        endcase
        @(negedge avmm_clk);
        avmm_cs = 1'b0; avmm_write = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [1:0] addr,
                            input logic [31:0] expected);
        @(negedge avmm_clk);
        avmm_cs = 1'b1; avmm_read = 1'b1; avmm_addr = addr;
        if (addr == 2'd3) m_rx_valid = 1'b0;
        @(negedge avmm_clk);
        avmm_cs = 1'b0; avmm_read = 1'b0;
        checkOutput(name, avmm_readdata, expected);
    endtask

    task automatic spiMaster(input int len, input int nclk, input logic cpol,
                             input logic cpha, input logic [31:0] mosi_word,
                             input int reset_at, output logic [31:0] miso_word);
        bit stopped;
        stopped = 1'b0;
        miso_word = 32'd0;
        @(negedge avmm_clk);
        spi_clk = cpol;
        repeat (4) @(negedge avmm_clk);
        spi_cs_n = 1'b0;
        if (!cpha) spi_mosi = mosi_word[5'(len - 1)];
        repeat (HALF) @(negedge avmm_clk);
        for (int i = 0; i < nclk && !stopped; i++) begin
            if (i == reset_at) begin
                avmm_reset = 1'b1;
                spi_cs_n = 1'b1;
                spi_clk = cpol;
                repeat (3) @(negedge avmm_clk);
                avmm_reset = 1'b0;
                stopped = 1'b1;
            end else begin
                spi_clk = ~cpol;
                if (cpha) spi_mosi = mosi_word[5'(len - 1 - i)];
                else      miso_word = {miso_word[30:0], spi_miso};
                repeat (HALF) @(negedge avmm_clk);
                spi_clk = cpol;
                if (cpha)             miso_word = {miso_word[30:0], spi_miso};
                else if (i + 1 < len) spi_mosi = mosi_word[5'(len - 2 - i)];
                repeat (HALF) @(negedge avmm_clk);
            end
        end
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (10) @(negedge avmm_clk);
    endtask

    task automatic runTransfer(input int nclk, input logic [31:0] mosi_word,
                               output logic [31:0] got);
        int          len;
        logic [31:0] mask;
        logic        en;
        len  = effLen(m_ctrl);
        mask = lenMask(len);
        en   = m_ctrl[0];
        if (en) settled = 1'b0;
        spiMaster(len, nclk, m_ctrl[1], m_ctrl[2], mosi_word, -1, got);
        if (nclk >= len)
            checkOutput("miso_word", got, en ? (m_tx & mask) : 32'd0);
        if (en) begin
            if (m_tx_empty) m_udr = 1'b1;
            m_tx_empty = 1'b1;
            if (nclk >= len) begin
                if (m_rx_valid) m_ovr = 1'b1;
                m_rx = mosi_word & mask;
                m_rx_valid = 1'b1;
            end else begin
                m_abort = 1'b1;
            end
        end
        settled = 1'b1;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] tx_pat [2];
        logic [31:0] rx_pat [2];
        int          lens   [2];
        tx_pat = '{32'h3C, 32'hDEAD_BEEF};
        rx_pat = '{32'h81, 32'hCAFE_F00D};
        lens   = '{8, 32};

        repeat (3) @(negedge avmm_clk);
        avmm_reset = 1'b0;
        settled = 1'b1;
        $display("[TB] reset values");
        checkReg("reset_ctrl", 2'd0, 32'h81);
        checkReg("reset_status", 2'd1, 32'h04);
        checkReg("reset_rx", 2'd3, 32'h0);

        $display("[TB] mode 0, 16 bits");
        applyStimulus(2'd2, 32'hA5C3);
        runTransfer(16, 32'h1234, got);
        checkOutput("mode0_miso_literal", got, 32'hA5C3);
        checkReg("mode0_status", 2'd1, 32'h06);
        checkReg("mode0_rx", 2'd3, 32'h1234);
        checkReg("mode0_status_after_read", 2'd1, modelStatus());

        $display("[TB] modes 1-3 at 8 and 32 bits");
        for (int mode = 1; mode < 4; mode++) begin
            for (int k = 0; k < 2; k++) begin
                applyStimulus(2'd0, 32'h1 | (32'(mode >> 1) << 1) | (32'(mode & 1) << 2)
                                          | (32'(lens[k]) << 3));
                applyStimulus(2'd2, tx_pat[k]);
                runTransfer(lens[k], rx_pat[k], got);
                checkOutput("mode_miso_literal", got, tx_pat[k]);
                checkReg("mode_status", 2'd1, modelStatus());
                checkReg("mode_rx", 2'd3, rx_pat[k]);
            end
        end

        $display("[TB] early abort");
        applyStimulus(2'd0, 32'h81);
        applyStimulus(2'd2, 32'h1111);
        runTransfer(5, 32'hFFFF, got);
        checkReg("abort_status", 2'd1, 32'h24);
        checkReg("abort_rx_unchanged", 2'd3, m_rx);
        applyStimulus(2'd1, 32'h20);
        checkReg("abort_cleared", 2'd1, 32'h04);

        $display("[TB] overrun and underrun");
        applyStimulus(2'd0, 32'h81 | (32'h1 << 19));
        applyStimulus(2'd2, 32'h0F0F);
        runTransfer(16, 32'hAAAA, got);
        runTransfer(16, 32'h5555, got);
        checkOutput("stale_tx_literal", got, 32'h0F0F);
        checkReg("ovr_udr_status", 2'd1, 32'h1E);
        checkReg("ovr_rx_second", 2'd3, 32'h5555);
        checkReg("ovr_status_after_read", 2'd1, 32'h1C);
        applyStimulus(2'd1, 32'h38);
        checkReg("flags_cleared", 2'd1, modelStatus());

        $display("[TB] disabled");
        applyStimulus(2'd0, 32'h80);
        applyStimulus(2'd2, 32'h1234);
        @(negedge avmm_clk);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge avmm_clk);
        checkReg("disabled_busy", 2'd1, 32'h00);
        @(negedge avmm_clk);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge avmm_clk);
        runTransfer(16, 32'hBEEF, got);
        checkReg("disabled_status", 2'd1, modelStatus());

        $display("[TB] reset mid-transfer");
        applyStimulus(2'd0, 32'h81);
        applyStimulus(2'd2, 32'h00FF);
        settled = 1'b0;
        spiMaster(16, 16, 1'b0, 1'b0, 32'hFFFF, 7, got);
        m_ctrl = 32'h81; m_tx = 32'd0; m_rx = 32'd0; m_tx_empty = 1'b1;
        m_rx_valid = 1'b0; m_ovr = 1'b0; m_udr = 1'b0; m_abort = 1'b0;
        settled = 1'b1;
        checkOutput("miso_after_reset", {31'd0, spi_miso}, 32'd0);
        checkReg("status_after_reset", 2'd1, 32'h04);
        checkReg("ctrl_after_reset", 2'd0, 32'h81);
        applyStimulus(2'd2, 32'h6C6C);
        runTransfer(16, 32'h9876, got);
        checkReg("post_reset_rx", 2'd3, 32'h9876);
        checkReg("post_reset_status", 2'd1, modelStatus());

        repeat (4) @(negedge avmm_clk);
        settled = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
